tick_pwm_gen: RTL

- Downstream consumer of the fast clock divider's single-cycle zero/tick output.
- Turns the divided tick stream into a programmable periodic waveform: period of P+1 ticks, high for H ticks. Drives ADC sample-gate and PPS-style outputs.
- New period/high values arrive via a valid/ready handshake, are held in a shadow register, and are applied only at a period boundary, so the output never glitches.

---
 rtl/tick_pwm_gen_pkg.sv | 16 +
 rtl/tick_pwm_gen_shadow.sv | 71 +++++++
 rtl/tick_pwm_gen.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/tick_pwm_gen_pkg.sv
// -----------------------------------------------------------------------------
// tick_pwm_gen_pkg
// Shared definitions for the tick-driven PWM generator.
//   - NBITS_DEFAULT : default width of the period, high-time and phase counter
//   - state_e       : run state of the generator (IDLE=0, RUN=1)
// -----------------------------------------------------------------------------
package tick_pwm_gen_pkg;

    localparam int NBITS_DEFAULT = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/tick_pwm_gen_shadow.sv
// -----------------------------------------------------------------------------
// tick_pwm_gen_shadow
// One-entry shadow register for period/high configuration. A new config is
// accepted over a valid/ready handshake, held here, and handed to the
// generator only when it signals an apply event.
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_cfg_valid               config offer
//   i_cfg_period, i_cfg_high  offered period (P) and high time (H)
//   i_apply                   apply strobe from the generator
//   o_cfg_ready               shadow slot free
//   o_full                    shadow holds a pending config
//   o_period, o_high          pending config contents
// -----------------------------------------------------------------------------
module tick_pwm_gen_shadow
    import tick_pwm_gen_pkg::*;
#(
    parameter int NBITS = NBITS_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cfg_valid,
    input  logic [NBITS-1:0] i_cfg_period,
    input  logic [NBITS-1:0] i_cfg_high,
    input  logic             i_apply,
    output logic             o_cfg_ready,
    output logic             o_full,
    output logic [NBITS-1:0] o_period,
    output logic [NBITS-1:0] o_high
);

    logic             full_q,   full_d;
    logic [NBITS-1:0] period_q, period_d;
    logic [NBITS-1:0] high_q,   high_d;
    logic             accept;

    // Accept is only possible while empty, so an apply in the same cycle
    // never sees the freshly accepted value: it waits for the next apply.
    always_comb begin
        full_d   = full_q;
        period_d = period_q;
        high_d   = high_q;
        accept   = i_cfg_valid && !full_q;
        if (i_apply && full_q) begin
            full_d = 1'b0;
        end
        if (accept) begin
            full_d   = 1'b1;
            period_d = i_cfg_period;
            high_d   = i_cfg_high;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            full_q   <= 1'b0;
            period_q <= '0;
            high_q   <= '0;
        end else begin
            full_q   <= full_d;
            period_q <= period_d;
            high_q   <= high_d;
        end
    end

    assign o_cfg_ready = !full_q;
    assign o_full      = full_q;
    assign o_period    = period_q;
    assign o_high      = high_q;

endmodule

// File: rtl/tick_pwm_gen.sv
// -----------------------------------------------------------------------------
// tick_pwm_gen
// Turns a single-cycle tick stream into a periodic waveform: a period lasts
// P+1 ticks and the output is high for the first H ticks of each period.
// Config updates go through a shadow register and take effect only at a
// period boundary (or on entry into RUN), so the output never glitches.
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_en                      run enable (level)
//   i_tick                    one-cycle tick from the divider
//   i_cfg_valid/o_cfg_ready   config handshake
//   i_cfg_period, i_cfg_high  offered P and H
//   o_out                     registered waveform
//   o_period_start            one-cycle pulse at each period start
//   o_busy                    generator is in RUN
//   o_phase                   current phase within the period (0..P)
// -----------------------------------------------------------------------------
module tick_pwm_gen
    import tick_pwm_gen_pkg::*;
#(
    parameter int NBITS = NBITS_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_tick,
    input  logic             i_cfg_valid,
    output logic             o_cfg_ready,
    input  logic [NBITS-1:0] i_cfg_period,
    input  logic [NBITS-1:0] i_cfg_high,
    output logic             o_out,
    output logic             o_period_start,
    output logic             o_busy,
    output logic [NBITS-1:0] o_phase
);

    state_e           state_q,  state_d;
    logic [NBITS-1:0] phase_q,  phase_d;
    logic [NBITS-1:0] period_q, period_d;
    logic [NBITS-1:0] high_q,   high_d;
    logic             out_q,    out_d;
    logic             start_q,  start_d;

    logic             apply;
    logic             sh_full;
    logic [NBITS-1:0] sh_period;
    logic [NBITS-1:0] sh_high;
    logic [NBITS-1:0] next_period;
    logic [NBITS-1:0] next_high;
    logic [NBITS-1:0] phase_inc;

    tick_pwm_gen_shadow #(
        .NBITS (NBITS)
    ) u_shadow (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_cfg_valid  (i_cfg_valid),
        .i_cfg_period (i_cfg_period),
        .i_cfg_high   (i_cfg_high),
        .i_apply      (apply),
        .o_cfg_ready  (o_cfg_ready),
        .o_full       (sh_full),
        .o_period     (sh_period),
        .o_high       (sh_high)
    );

    // Config that will be active after an apply event.
    assign next_period = sh_full ? sh_period : period_q;
    assign next_high   = sh_full ? sh_high   : high_q;

    // The phase never exceeds the active P, so this increment cannot wrap.
    assign phase_inc   = phase_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        period_d = period_q;
        high_d   = high_q;
        out_d    = out_q;
        start_d  = 1'b0;
        apply    = 1'b0;
        unique case (state_q)
            IDLE: begin
                phase_d = '0;
                out_d   = 1'b0;
                if (i_en) begin
                    state_d  = RUN;
                    start_d  = 1'b1;
                    apply    = 1'b1;
                    period_d = next_period;
                    high_d   = next_high;
                    out_d    = (next_high != '0);
                end
            end
            RUN: begin
                // Disable wins over a coincident tick.
                if (!i_en) begin
                    state_d = IDLE;
                    phase_d = '0;
                    out_d   = 1'b0;
                end else if (i_tick) begin
                    if (phase_q == period_q) begin
                        phase_d  = '0;
                        start_d  = 1'b1;
                        apply    = 1'b1;
                        period_d = next_period;
                        high_d   = next_high;
                        out_d    = (next_high != '0);
                    end else begin
                        phase_d = phase_inc;
                        out_d   = (phase_inc < high_q);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
                out_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            period_q <= '0;
            high_q   <= '0;
            out_q    <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            period_q <= period_d;
            high_q   <= high_d;
            out_q    <= out_d;
            start_q  <= start_d;
        end
    end

    assign o_out          = out_q;
    assign o_period_start = start_q;
    assign o_busy         = (state_q == RUN);
    assign o_phase        = phase_q;

endmodule
